imem_sync: RTL and testbench
============================

Name: imem_sync

Overview:
- Parametrised, synchronous instruction memory for the processor fetch stage.
- Replaces the combinational, initial-block-loaded store with a clocked block that has a loader write port and a fetch read port, each with a valid/ready handshake.
- Self-clears its whole array after reset.
- Reports out-of-range accesses as hardware error flags instead of simulation messages.

Parameters:
- DATA_W, 32, instruction word width in bits.
- ADDR_W, 10, address width of both ports.
- DEPTH, 1024, number of implemented words; legal range is 1..2**ADDR_W. Addresses >= DEPTH are out of range.
- CLR_VAL, 0, DATA_W-bit value written to every word during the post-reset clear.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- ld_valid  in  1  loader presents a write.
- ld_ready  out  1  loader write accepted this cycle when high together with ld_valid.
- ld_addr  in  ADDR_W  write word address.
- ld_data  in  DATA_W  write data.
- ld_err  out  1  one-cycle pulse: the previous accepted write was out of range.
- fe_req  in  1  fetch request.
- fe_ready  out  1  fetch request accepted when high together with fe_req.
- fe_addr  in  ADDR_W  fetch word address (PC).
- fe_valid  out  1  fe_data/fe_err are valid this cycle.
- fe_data  out  DATA_W  fetched instruction.
- fe_err  out  1  qualifies fe_valid: the fetch address was out of range.
- init_busy  out  1  post-reset clear in progress.

Behaviour:
Reset
- While rst_n=0: state=INIT, clear counter=0, ld_ready=0, fe_ready=0, ld_err=0, fe_valid=0, fe_data=0, fe_err=0, init_busy=1.
- Array contents are undefined until the clear completes.
- Reset asserted mid-clear or mid-run aborts everything; the clear restarts from word 0.

State machine: INIT -> RUN.
- INIT:
  - Each cycle writes CLR_VAL to word[counter], then counter increments.
  - The cycle that writes word DEPTH-1 moves to RUN.
  - INIT lasts exactly DEPTH cycles after reset release.
  - ld_ready=0, fe_ready=0, init_busy=1; requests are ignored, not queued.
- RUN:
  - ld_ready=1, fe_ready=1, init_busy=0.
  - Stays in RUN until reset.

Load
- An accepted write with ld_addr < DEPTH stores ld_data at the clock edge.
- If ld_addr >= DEPTH: the write is dropped, the array is unchanged, and ld_err=1 in the following cycle.
- ld_err is 0 in every other cycle.

Fetch
- Latency 1: an accepted request in cycle N gives fe_valid=1 in cycle N+1 with fe_data=word[fe_addr].
- Fully pipelined: back-to-back requests give back-to-back fe_valid.
- fe_valid=0 in any cycle after a cycle with no accepted request.
- fe_data holds its last value when fe_valid=0.
- If fe_addr >= DEPTH: fe_valid=1, fe_err=1, fe_data=0.
- fe_err=0 on every in-range response.

Simultaneous events
- Load and fetch to the same in-range address in the same cycle: write-first. The fetch returns the new ld_data.
- Out-of-range load plus fetch of any address: the fetch sees the unchanged array.

Width rules
- Address comparisons are unsigned and ADDR_W bits wide.
- When DEPTH=2**ADDR_W no out-of-range case exists; ld_err and fe_err stay 0.
- The clear counter is ADDR_W+1 bits wide so that DEPTH=2**ADDR_W terminates correctly.

Test Plan:
1. Reset release, DEPTH=1024, CLR_VAL=0 -> init_busy=1 and both ready signals 0 for exactly 1024 cycles, then RUN. Fetching addresses 0, 511 and 1023 returns 0 with fe_err=0.
2. Load 0x8000_0480 at address 0 and 0x2600_0000 at address 6. Fetch 0, 6, 0 back-to-back -> fe_valid high for 3 consecutive cycles carrying 0x8000_0480, 0x2600_0000, 0x8000_0480, each one cycle after its request.
3. Same cycle: load 0x1234_5678 to address 100 and fetch address 100 -> next cycle fe_data=0x1234_5678.
4. DEPTH=1000: load to address 1000 -> ld_err=1 for one cycle, and word 1000 is not stored. Fetch address 1023 -> fe_valid=1, fe_err=1, fe_data=0.
5. Assert rst_n=0 at clear counter=300 -> outputs return to reset values immediately, without waiting for a clock edge. After release, a full 1024-cycle clear runs, and a word loaded before reset reads back as CLR_VAL.
6. Requests presented during INIT (fe_req=1, ld_valid=1 with address 5, data 0xFFFF_FFFF) -> no fe_valid, no write; after INIT, address 5 reads CLR_VAL.

Source files
------------

// File: rtl/imem_if.sv
// Loader-write and fetch-read handshake bundle for the synchronous instruction memory.
interface imem_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);
    logic              ld_valid;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_err;
    logic              fe_req;
    logic              fe_ready;
    logic [ADDR_W-1:0] fe_addr;
    logic              fe_valid;
    logic [DATA_W-1:0] fe_data;
    logic              fe_err;
    logic              init_busy;

    modport master (
        output ld_valid, ld_addr, ld_data, fe_req, fe_addr,
        input  ld_ready, ld_err, fe_ready, fe_valid, fe_data, fe_err, init_busy
    );

    modport slave (
        input  ld_valid, ld_addr, ld_data, fe_req, fe_addr,
        output ld_ready, ld_err, fe_ready, fe_valid, fe_data, fe_err, init_busy
    );
endinterface

// File: rtl/imem_sync.sv
// Clocked instruction memory: self-clearing after reset, one write (loader) and one
// pipelined read (fetch) port, out-of-range accesses flagged in hardware.
module imem_sync #(
    parameter int                 DATA_W  = 32,
    parameter int                 ADDR_W  = 10,
    parameter int                 DEPTH   = 1024,
    parameter logic [DATA_W-1:0]  CLR_VAL = '0
) (
    input  logic   clk,
    input  logic   rst_n,
    imem_if.slave  bus
);

    typedef enum logic {INIT, RUN} state_t;

    // Counter is one bit wider than the address so DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0] DEPTH_W   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_WORD = (ADDR_W+1)'(DEPTH - 1);

    function automatic logic inRange(input logic [ADDR_W-1:0] addr);
        return {1'b0, addr} < DEPTH_W;
    endfunction

    state_t              state, stateNxt;
    logic [ADDR_W:0]     clrCnt, clrCntNxt;
    logic                ldReady, feReady, initBusy;

    logic                ldAccept, ldInRange, ldHit;
    logic                feAccept, feInRange;
    logic                wrEn;
    logic [ADDR_W-1:0]   wrAddr;
    logic [DATA_W-1:0]   wrData;
    logic [DATA_W-1:0]   rdData;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                ldErr_p1;
    logic                feVld_p1;
    logic                feErr_p1;
    logic [DATA_W-1:0]   feData_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= INIT;
            clrCnt <= '0;
        end else begin
            state  <= stateNxt;
            clrCnt <= clrCntNxt;
        end
    end

    always_comb begin
        stateNxt  = state;
        clrCntNxt = clrCnt;
        ldReady   = 1'b0;
        feReady   = 1'b0;
        initBusy  = 1'b1;
        case (state)
            INIT: begin
                clrCntNxt = clrCnt + 1'b1;
                if (clrCnt == LAST_WORD) stateNxt = RUN;
            end
            RUN: begin
                ldReady  = 1'b1;
                feReady  = 1'b1;
                initBusy = 1'b0;
            end
            default: stateNxt = INIT;
        endcase
    end

    assign ldAccept  = bus.ld_valid & ldReady;
    assign ldInRange = inRange(bus.ld_addr);
    assign ldHit     = ldAccept & ldInRange;
    assign feAccept  = bus.fe_req & feReady;
    assign feInRange = inRange(bus.fe_addr);

    // The clear sweep owns the write port during INIT; the loader owns it afterwards.
    always_comb begin
        wrEn   = 1'b0;
        wrAddr = bus.ld_addr;
        wrData = bus.ld_data;
        if (state == INIT) begin
            wrEn   = 1'b1;
            wrAddr = clrCnt[ADDR_W-1:0];
            wrData = CLR_VAL;
        end else if (ldHit) begin
            wrEn   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wrEn) mem[wrAddr] <= wrData;
    end

    // Write-first: a same-cycle load to the fetched word bypasses the array.
    always_comb begin
        rdData = '0;
        if (feInRange) begin
            if (ldHit && (bus.ld_addr == bus.fe_addr)) rdData = bus.ld_data;
            else                                       rdData = mem[bus.fe_addr];
        end
    end

    // ---- stage p0 -> p1: registered responses ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ldErr_p1  <= 1'b0;
            feVld_p1  <= 1'b0;
            feErr_p1  <= 1'b0;
            feData_p1 <= '0;
        end else begin
            ldErr_p1 <= ldAccept & ~ldInRange;
            feVld_p1 <= feAccept;
            feErr_p1 <= feAccept & ~feInRange;
            if (feAccept) feData_p1 <= rdData;
        end
    end

    assign bus.ld_ready  = ldReady;
    assign bus.fe_ready  = feReady;
    assign bus.init_busy = initBusy;
    assign bus.ld_err    = ldErr_p1;
    assign bus.fe_valid  = feVld_p1;
    assign bus.fe_err    = feErr_p1;
    assign bus.fe_data   = feData_p1;

endmodule

// File: tb/tb_imem_sync.sv
// Bench for imem_sync: two instances (full-depth and DEPTH=1000) against an array model.
module tb_imem_sync;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    imem_if #(.DATA_W(32), .ADDR_W(10)) ifA ();
    imem_if #(.DATA_W(32), .ADDR_W(10)) ifB ();

    imem_sync #(.DATA_W(32), .ADDR_W(10), .DEPTH(1024), .CLR_VAL(32'h0000_0000))
        dutA (.clk(clk), .rst_n(rst_n), .bus(ifA));
    imem_sync #(.DATA_W(32), .ADDR_W(10), .DEPTH(1000), .CLR_VAL(32'h5A5A_0F0F))
        dutB (.clk(clk), .rst_n(rst_n), .bus(ifB));

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mdl [2][1024];
    logic [31:0] lastData [2];
    int          depth [2]  = '{1024, 1000};
    logic [31:0] clrVal [2] = '{32'h0000_0000, 32'h5A5A_0F0F};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int b, input logic lv, input logic [9:0] la, input logic [31:0] ld,
                         input logic fr, input logic [9:0] fa);
        if (b == 0) begin
            ifA.ld_valid = lv; ifA.ld_addr = la; ifA.ld_data = ld;
            ifA.fe_req   = fr; ifA.fe_addr = fa;
        end else begin
            ifB.ld_valid = lv; ifB.ld_addr = la; ifB.ld_data = ld;
            ifB.fe_req   = fr; ifB.fe_addr = fa;
        end
    endtask

    task automatic getOut(input int b, output logic fv, output logic [31:0] fd,
                          output logic fe, output logic le);
        if (b == 0) begin
            fv = ifA.fe_valid; fd = ifA.fe_data; fe = ifA.fe_err; le = ifA.ld_err;
        end else begin
            fv = ifB.fe_valid; fd = ifB.fe_data; fe = ifB.fe_err; le = ifB.ld_err;
        end
    endtask

    task automatic modelReset();
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 1024; i++) mdl[b][i] = clrVal[b];
            lastData[b] = 32'h0;
        end
    endtask

    task automatic chkResetOutputs(input int b, input string tag);
        if (b == 0) begin
            chk({tag, " ld_ready"},  ifA.ld_ready,  1'b0);
            chk({tag, " fe_ready"},  ifA.fe_ready,  1'b0);
            chk({tag, " ld_err"},    ifA.ld_err,    1'b0);
            chk({tag, " fe_valid"},  ifA.fe_valid,  1'b0);
            chk({tag, " fe_data"},   ifA.fe_data,   32'h0);
            chk({tag, " fe_err"},    ifA.fe_err,    1'b0);
            chk({tag, " init_busy"}, ifA.init_busy, 1'b1);
        end else begin
            chk({tag, " ld_ready"},  ifB.ld_ready,  1'b0);
            chk({tag, " fe_ready"},  ifB.fe_ready,  1'b0);
            chk({tag, " ld_err"},    ifB.ld_err,    1'b0);
            chk({tag, " fe_valid"},  ifB.fe_valid,  1'b0);
            chk({tag, " fe_data"},   ifB.fe_data,   32'h0);
            chk({tag, " fe_err"},    ifB.fe_err,    1'b0);
            chk({tag, " init_busy"}, ifB.init_busy, 1'b1);
        end
    endtask

    // One clock of traffic on instance b; expectations come from the array model.
    task automatic step(input int b, input logic lv, input logic [9:0] la, input logic [31:0] ld,
                        input logic fr, input logic [9:0] fa, input string tag);
        logic [31:0] eData;
        logic        eErr, eLdErr;
        logic        fv, fe, le;
        logic [31:0] fd;
        eLdErr = lv && (int'(la) >= depth[b]);
        eErr   = 1'b0;
        eData  = lastData[b];
        if (fr) begin
            if (int'(fa) >= depth[b]) begin
                eErr  = 1'b1;
                eData = 32'h0;
            end else if (lv && !eLdErr && la == fa) begin
                eData = ld;
            end else begin
                eData = mdl[b][fa];
            end
            lastData[b] = eData;
        end
        if (lv && !eLdErr) mdl[b][la] = ld;
        drive(b, lv, la, ld, fr, fa);
        @(posedge clk); #1;
        drive(b, 1'b0, 10'd0, 32'h0, 1'b0, 10'd0);
        getOut(b, fv, fd, fe, le);
        chk({tag, " fe_valid"}, fv, fr);
        chk({tag, " fe_data"},  fd, eData);
        if (fr) chk({tag, " fe_err"}, fe, eErr);
        chk({tag, " ld_err"},   le, eLdErr);
    endtask

    // Counts clear cycles on both instances; optionally hammers requests while busy.
    task automatic runInit(input logic reqDuring, input string tag);
        int busyA = 0, rdyA = 0, busyB = 0, rdyB = 0, sawVal = 0, sawErr = 0;
        for (int i = 0; i < 1100; i++) begin
            if (ifA.init_busy) busyA++;
            if (!ifA.ld_ready && !ifA.fe_ready) rdyA++;
            if (ifB.init_busy) busyB++;
            if (!ifB.ld_ready && !ifB.fe_ready) rdyB++;
            if (reqDuring && ifA.init_busy) drive(0, 1'b1, 10'd5, 32'hFFFF_FFFF, 1'b1, 10'd5);
            else                            drive(0, 1'b0, 10'd0, 32'h0, 1'b0, 10'd0);
            if (reqDuring && ifB.init_busy) drive(1, 1'b1, 10'd5, 32'hFFFF_FFFF, 1'b1, 10'd5);
            else                            drive(1, 1'b0, 10'd0, 32'h0, 1'b0, 10'd0);
            @(posedge clk); #1;
            if (ifA.fe_valid || ifB.fe_valid) sawVal++;
            if (ifA.ld_err || ifB.ld_err)     sawErr++;
        end
        chk({tag, " A busy cycles"},  busyA, 1024);
        chk({tag, " A !ready cycles"}, rdyA, 1024);
        chk({tag, " B busy cycles"},  busyB, 1000);
        chk({tag, " B !ready cycles"}, rdyB, 1000);
        chk({tag, " fe_valid during init"}, sawVal, 0);
        chk({tag, " ld_err during init"},   sawErr, 0);
        chk({tag, " A ready after"}, {ifA.ld_ready, ifA.fe_ready, ifA.init_busy}, 3'b110);
        chk({tag, " B ready after"}, {ifB.ld_ready, ifB.fe_ready, ifB.init_busy}, 3'b110);
        modelReset();
    endtask

    initial begin
        logic [9:0]  ra, rf;
        logic [31:0] rd;
        int          b;

        rst_n = 1'b0;
        drive(0, 1'b0, 10'd0, 32'h0, 1'b0, 10'd0);
        drive(1, 1'b0, 10'd0, 32'h0, 1'b0, 10'd0);
        repeat (3) @(posedge clk);
        #1;
        chkResetOutputs(0, "rstA");
        chkResetOutputs(1, "rstB");

        rst_n = 1'b1;
        runInit(1'b1, "init1");

        step(0, 1'b0, 10'd0, 32'h0, 1'b1, 10'd5, "ignoredA5");
        step(1, 1'b0, 10'd0, 32'h0, 1'b1, 10'd5, "ignoredB5");

        step(0, 1'b0, 10'd0, 32'h0, 1'b1, 10'd0,    "clrA0");
        step(0, 1'b0, 10'd0, 32'h0, 1'b1, 10'd511,  "clrA511");
        step(0, 1'b0, 10'd0, 32'h0, 1'b1, 10'd1023, "clrA1023");

        step(0, 1'b1, 10'd0, 32'h8000_0480, 1'b0, 10'd0, "ldA0");
        step(0, 1'b1, 10'd6, 32'h2600_0000, 1'b0, 10'd0, "ldA6");
        step(0, 1'b0, 10'd0, 32'h0, 1'b1, 10'd0, "b2b0");
        step(0, 1'b0, 10'd0, 32'h0, 1'b1, 10'd6, "b2b6");
        step(0, 1'b0, 10'd0, 32'h0, 1'b1, 10'd0, "b2b0b");
        step(0, 1'b0, 10'd0, 32'h0, 1'b0, 10'd0, "holdA");

        step(0, 1'b1, 10'd100, 32'h1234_5678, 1'b1, 10'd100, "wfirstA");

        step(1, 1'b1, 10'd1000, 32'hABCD_EF01, 1'b0, 10'd0,    "ldOorB");
        step(1, 1'b0, 10'd0,    32'h0,         1'b0, 10'd0,    "ldErrGoneB");
        step(1, 1'b0, 10'd0,    32'h0,         1'b1, 10'd1023, "feOorB1023");
        step(1, 1'b1, 10'd1010, 32'h1111_2222, 1'b1, 10'd999,  "oorLdInFeB");
        step(1, 1'b1, 10'd999,  32'h3333_4444, 1'b1, 10'd999,  "wfirstB999");
        step(1, 1'b0, 10'd0,    32'h0,         1'b1, 10'd1000, "feOorB1000");

        for (int i = 0; i < 400; i++) begin
            b  = int'($urandom_range(0, 1));
            ra = (i % 3 == 0) ? 10'($urandom_range(990, 1023)) : 10'($urandom_range(0, 15));
            rf = (i % 4 == 0) ? 10'($urandom_range(990, 1023)) : 10'($urandom_range(0, 15));
            rd = $urandom;
            step(b, 1'($urandom_range(0, 1)), ra, rd, 1'($urandom_range(0, 1)), rf, "rand");
        end

        step(0, 1'b1, 10'd77, 32'hCAFE_F00D, 1'b0, 10'd0, "ldA77");
        step(0, 1'b0, 10'd0, 32'h0, 1'b1, 10'd77, "feA77");
        #2;
        rst_n = 1'b0;
        #1;
        chkResetOutputs(0, "asyncRstA");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        chk("midClear busy", ifA.init_busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chkResetOutputs(0, "midClearRstA");
        chkResetOutputs(1, "midClearRstB");
        @(posedge clk); #1;
        rst_n = 1'b1;
        runInit(1'b0, "init2");

        step(0, 1'b0, 10'd0, 32'h0, 1'b1, 10'd77,  "reclrA77");
        step(0, 1'b0, 10'd0, 32'h0, 1'b1, 10'd100, "reclrA100");
        step(1, 1'b0, 10'd0, 32'h0, 1'b1, 10'd999, "reclrB999");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
